// File: rtl/bitstream_streamer.sv
// Bitstream streamer: takes host bytes, serialises them LSB-first onto an
// AXI-stream master in BITSTREAM_DATA_WIDTH-bit beats while holding the fabric
// in configuration mode, then waits (bounded) for the fabric to report done.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | no load active; start begins a new bitstream
// FETCH    | byte_ready high, waiting for the next host byte
// SHIFT    | presenting beats of the current byte on m_tdata
// WAIT_CFG | whole bitstream sent, waiting for cfg_ready (with timeout)
// FINISH   | one-cycle done pulse, cfg released
module bitstream_streamer #(
  parameter int BITSTREAM_DATA_WIDTH = 1,
  parameter int BITSTREAM_LENGTH     = 64,
  parameter int DONE_TIMEOUT         = 255
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic [7:0]                      byte_in,
  input  logic                            byte_valid,
  output logic                            byte_ready,
  output logic [BITSTREAM_DATA_WIDTH-1:0] m_tdata,
  output logic                            m_tvalid,
  input  logic                            m_tready,
  output logic                            m_tlast,
  output logic                            cfg,
  input  logic                            cfg_ready,
  output logic                            busy,
  output logic                            done,
  output logic                            error
);

  localparam int CNT_W = $clog2(BITSTREAM_LENGTH + 1);
  localparam int TO_W  = $clog2(DONE_TIMEOUT + 1);

  localparam logic [CNT_W-1:0] BEAT_STEP = CNT_W'(BITSTREAM_DATA_WIDTH);
  localparam logic [CNT_W-1:0] LAST_POS  = CNT_W'(BITSTREAM_LENGTH);
  // Timeout fires on the cycle the counter would reach DONE_TIMEOUT.
  localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(DONE_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_SHIFT,
    S_WAIT_CFG,
    S_FINISH
  } state_e;

  state_e             state_q, state_d;
  logic [7:0]         sreg_q, sreg_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
  logic               error_q, error_d;

  logic [CNT_W-1:0]   bit_cnt_nxt;
  logic               last_beat;
  logic               byte_end;

  // Bit position after the beat currently on the bus is accepted.
  assign bit_cnt_nxt = bit_cnt_q + BEAT_STEP;
  assign last_beat   = (bit_cnt_nxt == LAST_POS);
  // Beat widths divide 8, so a byte is exhausted when the position is byte-aligned.
  assign byte_end    = (bit_cnt_nxt[2:0] == 3'd0);

  // Outputs are decoded from registered state so they are glitch-free and
  // drop together with the async reset.
  assign byte_ready = (state_q == S_FETCH);
  assign m_tvalid   = (state_q == S_SHIFT);
  assign m_tdata    = sreg_q[BITSTREAM_DATA_WIDTH-1:0];
  assign m_tlast    = (state_q == S_SHIFT) && last_beat;
  assign cfg        = (state_q == S_FETCH) || (state_q == S_SHIFT) ||
                      (state_q == S_WAIT_CFG);
  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_FINISH);
  assign error      = error_q;

  // State, datapath and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      sreg_q    <= 8'd0;
      bit_cnt_q <= '0;
      to_cnt_q  <= '0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      sreg_q    <= sreg_d;
      bit_cnt_q <= bit_cnt_d;
      to_cnt_q  <= to_cnt_d;
      error_q   <= error_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d   = state_q;
    sreg_d    = sreg_q;
    bit_cnt_d = bit_cnt_q;
    to_cnt_d  = to_cnt_q;
    error_d   = error_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          error_d   = 1'b0;
          bit_cnt_d = '0;
          state_d   = S_FETCH;
        end
      end

      S_FETCH: begin
        if (byte_valid) begin
          sreg_d  = byte_in;
          state_d = S_SHIFT;
        end
      end

      S_SHIFT: begin
        if (m_tready) begin
          sreg_d    = sreg_q >> BITSTREAM_DATA_WIDTH;
          bit_cnt_d = bit_cnt_nxt;
          if (last_beat) begin
            to_cnt_d = '0;
            state_d  = S_WAIT_CFG;
          end else if (byte_end) begin
            state_d  = S_FETCH;
          end
        end
      end

      S_WAIT_CFG: begin
        if (cfg_ready) begin
          state_d = S_FINISH;
        end else if (to_cnt_q == TO_LAST) begin
          error_d = 1'b1;
          state_d = S_IDLE;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end

      S_FINISH: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: doc/bitstream_streamer.md
BITSTREAM_STREAMER -- requirements
Module: bitstream_streamer

Interface
REQ-001 Parameter BITSTREAM_DATA_WIDTH, default 1: beat width of the AXI-stream master; SHALL be 1, 2, 4 or 8.
REQ-002 Parameter BITSTREAM_LENGTH, default 64: total bitstream bits; SHALL be a multiple of 8 and at least 8.
REQ-003 Parameter DONE_TIMEOUT, default 255: maximum cycles to wait for cfg_ready after the last beat; at least 1.
REQ-004 clk  input  1  sole clock; all state on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 start  input  1  single-cycle request to begin a configuration load.
REQ-007 byte_in  input  8  host bitstream byte.
REQ-008 byte_valid  input  1  byte_in is valid.
REQ-009 byte_ready  output  1  streamer accepts byte_in this cycle.
REQ-010 m_tdata  output  BITSTREAM_DATA_WIDTH  bitstream beat toward the fabric slave.
REQ-011 m_tvalid  output  1  beat valid.
REQ-012 m_tready  input  1  fabric accepts beat.
REQ-013 m_tlast  output  1  final beat of the bitstream.
REQ-014 cfg  output  1  holds the fabric in configuration mode.
REQ-015 cfg_ready  input  1  fabric reports configuration complete.
REQ-016 busy  output  1  load in progress (any state except IDLE).
REQ-017 done  output  1  one-cycle pulse on successful completion.
REQ-018 error  output  1  sticky; set on timeout, cleared by the next accepted start or by reset.

Function
REQ-019 FSM states SHALL be IDLE, FETCH, SHIFT, WAIT_CFG, FINISH.
REQ-020 IDLE: start=1 SHALL clear error, reset bit counter to 0, assert cfg, and go to FETCH; start outside IDLE SHALL be ignored.
REQ-021 FETCH: byte_ready SHALL be 1; on byte_valid&byte_ready, the byte SHALL load into the shift register and the FSM SHALL enter SHIFT the next cycle.
REQ-022 SHIFT: m_tvalid SHALL be 1, m_tdata SHALL equal the lowest BITSTREAM_DATA_WIDTH bits of the shift register (LSB-first); byte_ready SHALL be 0.
REQ-023 On m_tvalid&m_tready, the shift register SHALL shift right by BITSTREAM_DATA_WIDTH and the bit counter SHALL advance by BITSTREAM_DATA_WIDTH.
REQ-024 m_tdata, m_tlast and m_tvalid SHALL hold stable while m_tvalid=1 and m_tready=0 (AXI-stream rule).
REQ-025 m_tlast SHALL be 1 only on the beat whose bits end at counter position BITSTREAM_LENGTH.
REQ-026 After the last beat of a byte is accepted: if bits remain, go to FETCH; after the m_tlast beat is accepted, go to WAIT_CFG.
REQ-027 No bubble beyond FETCH: byte acceptance to first beat valid SHALL be exactly 1 cycle; beats of one byte SHALL be back-to-back under continuous m_tready.
REQ-028 WAIT_CFG: cfg SHALL stay 1; a timeout counter SHALL increment each cycle; cfg_ready=1 SHALL go to FINISH; reaching DONE_TIMEOUT cycles with cfg_ready=0 SHALL set error, deassert cfg, and return to IDLE.
REQ-029 FINISH: done SHALL pulse high for exactly one cycle, cfg SHALL deassert in that same cycle, and the FSM SHALL return to IDLE.
REQ-030 cfg_ready observed outside WAIT_CFG SHALL be ignored.
REQ-031 Counters SHALL be sized to $clog2(BITSTREAM_LENGTH+1) and $clog2(DONE_TIMEOUT+1) bits; no wrap-around is permitted within a load.
REQ-032 byte_valid without byte_ready SHALL NOT alter state.

Reset
REQ-033 rst_n=0 SHALL immediately force state IDLE and byte_ready=0, m_tvalid=0, m_tdata=0, m_tlast=0, cfg=0, busy=0, done=0, error=0, and all counters/shift register to 0.
REQ-034 Reset mid-load SHALL abort the load without emitting any further beat; the first start after reset SHALL begin a complete new bitstream.

Verification
REQ-035 Width 1, length 16, bytes 0xA5,0x3C, m_tready=1 -> m_tdata sequence 1,0,1,0,0,1,0,1,0,0,1,1,1,1,0,0; m_tlast only on beat 16; cfg_ready after 3 cycles -> done one pulse, cfg falls same cycle.
REQ-036 Width 4, length 8, byte 0x5E, m_tready toggled 1/0 -> beats 0xE then 0x5, each held stable while stalled, m_tlast on 0x5.
REQ-037 Length 8, cfg_ready held 0, DONE_TIMEOUT 4 -> error=1 four cycles after the tlast handshake, cfg=0, busy=0, done never pulses; next start clears error.
REQ-038 Assert rst_n=0 during the 5th beat of 0xFF -> all outputs 0 asynchronously; after release and start, the full 16-bit stream re-emits from bit 0.
REQ-039 start pulsed during SHIFT and cfg_ready pulsed during FETCH -> no effect on beat count or state sequence.
REQ-040 byte_valid delayed 10 cycles in FETCH -> m_tvalid=0 and byte_ready=1 throughout, stream resumes 1 cycle after acceptance.
